// File: rtl/segre_mm_arbiter_pkg.sv
// segre_mm_arbiter_pkg -- state encoding, requester identifiers and the default
// timeout for the main-memory arbiter.
package segre_mm_arbiter_pkg;

   typedef enum logic [1:0] {
      MM_ARB_IDLE = 2'd0,
      MM_ARB_BUSY = 2'd1,
      MM_ARB_RESP = 2'd2
   } mm_arb_state_e;

   // Requester identity; DC doubles as the reset favourite of the round robin.
   typedef enum logic {
      MM_OWNER_DC = 1'b0,
      MM_OWNER_IC = 1'b1
   } mm_arb_owner_e;

   localparam int unsigned MM_ARB_TIMEOUT_CYCLES = 256;

endpackage : segre_mm_arbiter_pkg

// File: rtl/segre_pkg.sv
// segre_pkg -- core-wide sizes shared by the cache and memory-side blocks.
package segre_pkg;

   localparam int unsigned ADDR_SIZE        = 32;
   localparam int unsigned DCACHE_LANE_SIZE = 128;
   localparam int unsigned ICACHE_LANE_SIZE = 64;

endpackage : segre_pkg

// File: rtl/segre_rr_arbiter.sv
// segre_rr_arbiter -- two-way round-robin selector between dcache (req_i[0])
// and icache (req_i[1]). The pointer favours dcache out of reset and, once a
// transaction completes, favours the requester that was not just served.
module segre_rr_arbiter
   import segre_mm_arbiter_pkg::*;
(
   input  logic          clk_i,
   input  logic          rsn_i,
   input  logic [1:0]    req_i,
   input  logic          upd_i,
   input  mm_arb_owner_e upd_owner_i,
   output logic          valid_o,
   output mm_arb_owner_e sel_o
);

   logic prio_ic_q;
   logic prio_ic_d;

   // Select a requester; only a simultaneous request consults the pointer.
   always_comb begin
      valid_o = 1'b0;
      sel_o   = MM_OWNER_DC;
      case (req_i)
         2'b01: begin
            valid_o = 1'b1;
            sel_o   = MM_OWNER_DC;
         end
         2'b10: begin
            valid_o = 1'b1;
            sel_o   = MM_OWNER_IC;
         end
         2'b11: begin
            valid_o = 1'b1;
            sel_o   = prio_ic_q ? MM_OWNER_IC : MM_OWNER_DC;
         end
         default: begin
            valid_o = 1'b0;
            sel_o   = MM_OWNER_DC;
         end
      endcase
   end

   // Next pointer: after serving an owner, favour the other requester.
   always_comb begin
      prio_ic_d = prio_ic_q;
      if (upd_i) begin
         prio_ic_d = (upd_owner_i == MM_OWNER_DC);
      end else begin
         prio_ic_d = prio_ic_q;
      end
   end

   // Pointer register, reset to favour dcache.
   always_ff @(posedge clk_i or posedge rsn_i) begin
      if (rsn_i) begin
         prio_ic_q <= 1'b0;
      end else begin
         prio_ic_q <= prio_ic_d;
      end
   end

endmodule : segre_rr_arbiter

// File: rtl/segre_mm_arbiter.sv
// segre_mm_arbiter -- shares one main-memory port between the dcache
// (refill read / write-back) and the icache (refill read).
// IDLE arbitrates and latches the request, BUSY drives the memory request
// until mm_data_rdy_i, RESP pulses the owner's rdy for one cycle.
// Optional feature macro: SEGRE_MM_ARB_TIMEOUT_EN -- aborts a transaction that
// has been BUSY for TIMEOUT_CYCLES cycles, returning a zero lane and timeout_o.
module segre_mm_arbiter
   import segre_pkg::*;
   import segre_mm_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = MM_ARB_TIMEOUT_CYCLES
) (
   input  logic                        clk_i,
   input  logic                        rsn_i,
   input  logic                        dc_req_i,
   input  logic                        dc_we_i,
   input  logic [ADDR_SIZE-1:0]        dc_addr_i,
   input  logic [DCACHE_LANE_SIZE-1:0] dc_data_i,
   output logic                        dc_gnt_o,
   output logic                        dc_rdy_o,
   output logic [DCACHE_LANE_SIZE-1:0] dc_data_o,
   input  logic                        ic_req_i,
   input  logic [ADDR_SIZE-1:0]        ic_addr_i,
   output logic                        ic_gnt_o,
   output logic                        ic_rdy_o,
   output logic [ICACHE_LANE_SIZE-1:0] ic_data_o,
   output logic                        mm_rd_req_o,
   output logic                        mm_wr_req_o,
   output logic [ADDR_SIZE-1:0]        mm_addr_o,
   output logic [DCACHE_LANE_SIZE-1:0] mm_data_o,
   input  logic                        mm_data_rdy_i,
   input  logic [DCACHE_LANE_SIZE-1:0] mm_data_i,
   output logic                        timeout_o
);

   mm_arb_state_e                state_q, state_d;
   mm_arb_owner_e                owner_q, owner_d;
   logic                         we_q, we_d;
   logic [ADDR_SIZE-1:0]         addr_q, addr_d;
   logic [DCACHE_LANE_SIZE-1:0]  wdata_q, wdata_d;
   logic                         dc_gnt_q, dc_gnt_d;
   logic                         ic_gnt_q, ic_gnt_d;
   logic                         dc_rdy_q, dc_rdy_d;
   logic                         ic_rdy_q, ic_rdy_d;
   logic                         rd_req_q, rd_req_d;
   logic                         wr_req_q, wr_req_d;
   logic [DCACHE_LANE_SIZE-1:0]  dc_data_q, dc_data_d;
   logic [ICACHE_LANE_SIZE-1:0]  ic_data_q, ic_data_d;

   logic                         rr_valid_s;
   mm_arb_owner_e                rr_sel_s;
   logic                         rr_upd_s;
   logic                         timeout_hit_s;

   segre_rr_arbiter u_rr (
      .clk_i       (clk_i),
      .rsn_i       (rsn_i),
      .req_i       ({ic_req_i, dc_req_i}),
      .upd_i       (rr_upd_s),
      .upd_owner_i (owner_q),
      .valid_o     (rr_valid_s),
      .sel_o       (rr_sel_s)
   );

   // Next state, latched request and next values of every registered output.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      dc_gnt_d  = 1'b0;
      ic_gnt_d  = 1'b0;
      dc_rdy_d  = 1'b0;
      ic_rdy_d  = 1'b0;
      rd_req_d  = 1'b0;
      wr_req_d  = 1'b0;
      dc_data_d = dc_data_q;
      ic_data_d = ic_data_q;
      rr_upd_s  = 1'b0;
      case (state_q)
         MM_ARB_IDLE: begin
            if (rr_valid_s) begin
               state_d = MM_ARB_BUSY;
               owner_d = rr_sel_s;
               if (rr_sel_s == MM_OWNER_IC) begin
                  we_d     = 1'b0;
                  addr_d   = ic_addr_i;
                  wdata_d  = {DCACHE_LANE_SIZE{1'b0}};
                  ic_gnt_d = 1'b1;
               end else begin
                  we_d     = dc_we_i;
                  addr_d   = dc_addr_i;
                  wdata_d  = dc_data_i;
                  dc_gnt_d = 1'b1;
               end
               rd_req_d = ~we_d;
               wr_req_d = we_d;
            end else begin
               state_d = MM_ARB_IDLE;
            end
         end
         MM_ARB_BUSY: begin
            // Memory completion wins over a timeout in the same cycle.
            if (mm_data_rdy_i || timeout_hit_s) begin
               state_d = MM_ARB_RESP;
               if (owner_q == MM_OWNER_IC) begin
                  ic_rdy_d = 1'b1;
                  if (!mm_data_rdy_i) begin
                     ic_data_d = {ICACHE_LANE_SIZE{1'b0}};
                  end else if (!we_q) begin
                     ic_data_d = mm_data_i[ICACHE_LANE_SIZE-1:0];
                  end else begin
                     ic_data_d = ic_data_q;
                  end
               end else begin
                  dc_rdy_d = 1'b1;
                  if (!mm_data_rdy_i) begin
                     dc_data_d = {DCACHE_LANE_SIZE{1'b0}};
                  end else if (!we_q) begin
                     dc_data_d = mm_data_i;
                  end else begin
                     dc_data_d = dc_data_q;
                  end
               end
            end else begin
               rd_req_d = ~we_q;
               wr_req_d = we_q;
            end
         end
         MM_ARB_RESP: begin
            state_d  = MM_ARB_IDLE;
            rr_upd_s = 1'b1;
         end
         default: begin
            state_d = MM_ARB_IDLE;
         end
      endcase
   end

   // State, latched request and registered outputs; reset abandons any transfer.
   always_ff @(posedge clk_i or posedge rsn_i) begin
      if (rsn_i) begin
         state_q   <= MM_ARB_IDLE;
         owner_q   <= MM_OWNER_DC;
         we_q      <= 1'b0;
         addr_q    <= {ADDR_SIZE{1'b0}};
         wdata_q   <= {DCACHE_LANE_SIZE{1'b0}};
         dc_gnt_q  <= 1'b0;
         ic_gnt_q  <= 1'b0;
         dc_rdy_q  <= 1'b0;
         ic_rdy_q  <= 1'b0;
         rd_req_q  <= 1'b0;
         wr_req_q  <= 1'b0;
         dc_data_q <= {DCACHE_LANE_SIZE{1'b0}};
         ic_data_q <= {ICACHE_LANE_SIZE{1'b0}};
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         dc_gnt_q  <= dc_gnt_d;
         ic_gnt_q  <= ic_gnt_d;
         dc_rdy_q  <= dc_rdy_d;
         ic_rdy_q  <= ic_rdy_d;
         rd_req_q  <= rd_req_d;
         wr_req_q  <= wr_req_d;
         dc_data_q <= dc_data_d;
         ic_data_q <= ic_data_d;
      end
   end

`ifdef SEGRE_MM_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_q, timeout_d;

   // Count BUSY cycles; the count is zero on every BUSY entry.
   always_comb begin
      cnt_d         = {CNT_W{1'b0}};
      timeout_hit_s = 1'b0;
      timeout_d     = 1'b0;
      if (state_q == MM_ARB_BUSY) begin
         cnt_d         = cnt_q + CNT_W'(1'b1);
         timeout_hit_s = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
         timeout_d     = timeout_hit_s & ~mm_data_rdy_i;
      end else begin
         cnt_d         = {CNT_W{1'b0}};
         timeout_hit_s = 1'b0;
         timeout_d     = 1'b0;
      end
   end

   // Counter and timeout flag registers.
   always_ff @(posedge clk_i or posedge rsn_i) begin
      if (rsn_i) begin
         cnt_q     <= {CNT_W{1'b0}};
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout_o = timeout_q;
`else
   // Without the timeout BUSY waits for memory indefinitely.
   assign timeout_hit_s = 1'b0;
   assign timeout_o     = 1'b0;

   // TIMEOUT_CYCLES only matters when the timeout is built in.
   if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
   end
`endif

   assign dc_gnt_o    = dc_gnt_q;
   assign ic_gnt_o    = ic_gnt_q;
   assign dc_rdy_o    = dc_rdy_q;
   assign ic_rdy_o    = ic_rdy_q;
   assign dc_data_o   = dc_data_q;
   assign ic_data_o   = ic_data_q;
   assign mm_rd_req_o = rd_req_q;
   assign mm_wr_req_o = wr_req_q;
   assign mm_addr_o   = addr_q;
   assign mm_data_o   = wdata_q;

endmodule : segre_mm_arbiter

// File: tb/tb_segre_mm_arbiter.sv
// tb_segre_mm_arbiter -- directed scenarios plus randomized traffic, checked
// every cycle against a transaction-level model of the arbiter.
// Honours SEGRE_MM_ARB_TIMEOUT_EN (DUT built with TIMEOUT_CYCLES = 8).
module tb_segre_mm_arbiter;
   import segre_pkg::*;

   localparam int AW = ADDR_SIZE;
   localparam int DW = DCACHE_LANE_SIZE;
   localparam int IW = ICACHE_LANE_SIZE;
   localparam int TO = 8;

   logic          clk_i = 1'b0;
   logic          rsn_i = 1'b1;
   logic          dc_req_i = 1'b0, dc_we_i = 1'b0;
   logic [AW-1:0] dc_addr_i = '0;
   logic [DW-1:0] dc_data_i = '0;
   logic          dc_gnt_o, dc_rdy_o;
   logic [DW-1:0] dc_data_o;
   logic          ic_req_i = 1'b0;
   logic [AW-1:0] ic_addr_i = '0;
   logic          ic_gnt_o, ic_rdy_o;
   logic [IW-1:0] ic_data_o;
   logic          mm_rd_req_o, mm_wr_req_o;
   logic [AW-1:0] mm_addr_o;
   logic [DW-1:0] mm_data_o;
   logic          mm_data_rdy_i = 1'b0;
   logic [DW-1:0] mm_data_i = '0;
   logic          timeout_o;

   always #5 clk_i = ~clk_i;

   segre_mm_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .clk_i(clk_i), .rsn_i(rsn_i),
      .dc_req_i(dc_req_i), .dc_we_i(dc_we_i), .dc_addr_i(dc_addr_i), .dc_data_i(dc_data_i),
      .dc_gnt_o(dc_gnt_o), .dc_rdy_o(dc_rdy_o), .dc_data_o(dc_data_o),
      .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i),
      .ic_gnt_o(ic_gnt_o), .ic_rdy_o(ic_rdy_o), .ic_data_o(ic_data_o),
      .mm_rd_req_o(mm_rd_req_o), .mm_wr_req_o(mm_wr_req_o), .mm_addr_o(mm_addr_o),
      .mm_data_o(mm_data_o), .mm_data_rdy_i(mm_data_rdy_i), .mm_data_i(mm_data_i),
      .timeout_o(timeout_o)
   );

   int checks = 0;
   int errors = 0;

   // Transaction-level model: one outstanding transfer, one response slot.
   bit            m_active, m_in_resp, m_prio_ic, m_owner_ic, m_we;
   int            m_busy;
   bit            e_dc_gnt, e_ic_gnt, e_dc_rdy, e_ic_rdy, e_rd, e_wr, e_to;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_wdata, e_dc_data;
   logic [IW-1:0] e_ic_data;

   int n_dc_gnt = 0, n_ic_gnt = 0, n_dc_rdy = 0, n_ic_rdy = 0;
   bit gnt_order[$];

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_active = 0; m_in_resp = 0; m_prio_ic = 0; m_owner_ic = 0; m_we = 0; m_busy = 0;
      e_dc_gnt = 0; e_ic_gnt = 0; e_dc_rdy = 0; e_ic_rdy = 0; e_rd = 0; e_wr = 0; e_to = 0;
      e_addr = '0; e_wdata = '0; e_dc_data = '0; e_ic_data = '0;
   endtask

   // Advance the model by one clock edge using the inputs sampled at that edge.
   task automatic model_step();
      bit pick_ic, fin, tmo;
      e_dc_gnt = 0; e_ic_gnt = 0; e_dc_rdy = 0; e_ic_rdy = 0; e_rd = 0; e_wr = 0; e_to = 0;
      if (rsn_i) begin
         model_reset();
      end else if (m_in_resp) begin
         m_in_resp = 0;
         m_prio_ic = !m_owner_ic;
      end else if (!m_active) begin
         if (dc_req_i || ic_req_i) begin
            pick_ic    = ic_req_i && (!dc_req_i || m_prio_ic);
            m_owner_ic = pick_ic;
            m_we       = pick_ic ? 1'b0 : dc_we_i;
            e_addr     = pick_ic ? ic_addr_i : dc_addr_i;
            e_wdata    = pick_ic ? '0 : dc_data_i;
            m_active   = 1; m_busy = 0;
            e_dc_gnt   = !pick_ic; e_ic_gnt = pick_ic;
            e_rd       = !m_we; e_wr = m_we;
         end
      end else begin
         m_busy++;
         fin = mm_data_rdy_i;
         tmo = 0;
`ifdef SEGRE_MM_ARB_TIMEOUT_EN
         if (!fin && m_busy == TO) begin
            fin = 1; tmo = 1;
         end
`endif
         if (fin) begin
            m_active = 0; m_in_resp = 1; e_to = tmo;
            if (m_owner_ic) begin
               e_ic_rdy = 1;
               if (tmo) e_ic_data = '0;
               else if (!m_we) e_ic_data = mm_data_i[IW-1:0];
            end else begin
               e_dc_rdy = 1;
               if (tmo) e_dc_data = '0;
               else if (!m_we) e_dc_data = mm_data_i;
            end
         end else begin
            e_rd = !m_we; e_wr = m_we;
         end
      end
   endtask

   // Compare every DUT output against the model for the current cycle.
   task automatic compare();
      chk1("dc_gnt", dc_gnt_o, e_dc_gnt);
      chk1("ic_gnt", ic_gnt_o, e_ic_gnt);
      chk1("dc_rdy", dc_rdy_o, e_dc_rdy);
      chk1("ic_rdy", ic_rdy_o, e_ic_rdy);
      chk1("mm_rd_req", mm_rd_req_o, e_rd);
      chk1("mm_wr_req", mm_wr_req_o, e_wr);
      chk1("timeout", timeout_o, e_to);
      chkw("dc_data", dc_data_o, e_dc_data);
      chkw("ic_data", DW'(ic_data_o), DW'(e_ic_data));
      if (e_rd || e_wr) begin
         chkw("mm_addr", DW'(mm_addr_o), DW'(e_addr));
         chkw("mm_data", mm_data_o, e_wdata);
      end
      if (dc_gnt_o) begin n_dc_gnt++; gnt_order.push_back(1'b0); end
      if (ic_gnt_o) begin n_ic_gnt++; gnt_order.push_back(1'b1); end
      if (dc_rdy_o) n_dc_rdy++;
      if (ic_rdy_o) n_ic_rdy++;
   endtask

   task automatic tick();
      @(posedge clk_i);
      model_step();
      @(negedge clk_i);
      compare();
   endtask

   function automatic logic [DW-1:0] rand_lane();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic do_reset();
      @(negedge clk_i);
      rsn_i = 1'b1; dc_req_i = 0; ic_req_i = 0; mm_data_rdy_i = 0;
      model_reset();
      repeat (2) tick();
      rsn_i = 1'b0;
   endtask

   task automatic drive_random(input int pct);
      if (dc_req_i && (dc_gnt_o || $urandom_range(99) < 3)) dc_req_i = 1'b0;
      if (!dc_req_i && $urandom_range(99) < 35) begin
         dc_req_i = 1'b1; dc_we_i = 1'($urandom_range(1));
         dc_addr_i = $urandom(); dc_data_i = rand_lane();
      end
      if (ic_req_i && (ic_gnt_o || $urandom_range(99) < 3)) ic_req_i = 1'b0;
      if (!ic_req_i && $urandom_range(99) < 35) begin
         ic_req_i = 1'b1; ic_addr_i = $urandom();
      end
      mm_data_rdy_i = ($urandom_range(99) < pct);
      mm_data_i     = rand_lane();
   endtask

   localparam logic [DW-1:0] LANE  = 128'hffeeddccbbaa99887766554433221100;
   localparam logic [DW-1:0] WDATA = 128'hcafebabe_deadbeef_01234567_89abcdef;

   initial begin
      int g0, r0, n;
      bit seen;
      model_reset();
      do_reset();
      // Reset state, pinned with literals.
      chk1("rst_dc_gnt", dc_gnt_o, 1'b0);
      chk1("rst_mm_rd", mm_rd_req_o, 1'b0);
      chk1("rst_timeout", timeout_o, 1'b0);
      chkw("rst_dc_data", dc_data_o, '0);
      chkw("rst_mm_addr", DW'(mm_addr_o), '0);

      // dcache refill read, memory answers 3 cycles after the read request.
      mm_data_rdy_i = 1'b1;               // ignored while idle
      mm_data_i = rand_lane();
      tick();
      mm_data_rdy_i = 1'b0;
      g0 = n_dc_gnt; r0 = n_dc_rdy;
      dc_req_i = 1; dc_we_i = 0; dc_addr_i = 32'h0000_0100;
      tick();
      chk1("rd_gnt", dc_gnt_o, 1'b1);
      chk1("rd_req", mm_rd_req_o, 1'b1);
      chkw("rd_addr", DW'(mm_addr_o), DW'(32'h0000_0100));
      dc_req_i = 0;
      repeat (3) tick();
      mm_data_rdy_i = 1; mm_data_i = LANE;
      tick();
      mm_data_rdy_i = 0; mm_data_i = rand_lane();
      chk1("rd_rdy", dc_rdy_o, 1'b1);
      chkw("rd_lane", dc_data_o, LANE);
      chk1("rd_resp_req_low", mm_rd_req_o, 1'b0);
      repeat (2) tick();
      chkw("rd_gnt_count", DW'(n_dc_gnt - g0), DW'(1));
      chkw("rd_rdy_count", DW'(n_dc_rdy - r0), DW'(1));

      // dcache write-back: refill lane must survive.
      dc_req_i = 1; dc_we_i = 1; dc_addr_i = 32'h0000_0200; dc_data_i = WDATA;
      tick();
      dc_req_i = 0;
      chk1("wr_req", mm_wr_req_o, 1'b1);
      chkw("wr_addr", DW'(mm_addr_o), DW'(32'h0000_0200));
      chkw("wr_data", mm_data_o, WDATA);
      mm_data_rdy_i = 1;
      tick();
      mm_data_rdy_i = 0;
      chk1("wr_rdy", dc_rdy_o, 1'b1);
      chkw("wr_lane_kept", dc_data_o, LANE);
      repeat (2) tick();

      // Both requesting from reset and held: dc, ic, dc, ic at minimum latency.
      do_reset();
      gnt_order.delete();
      dc_req_i = 1; dc_we_i = 0; dc_addr_i = 32'h0000_0300;
      ic_req_i = 1; ic_addr_i = 32'h0000_0400;
      mm_data_rdy_i = 1; mm_data_i = LANE;
      repeat (12) tick();
      dc_req_i = 0; ic_req_i = 0; mm_data_rdy_i = 0;
      repeat (4) tick();
      chkw("rr_count", DW'(gnt_order.size()), DW'(4));
      for (int k = 0; k < 4; k++) begin
         if (k < gnt_order.size()) chk1("rr_order", gnt_order[k], 1'(k % 2));
      end
      chkw("ic_lane_low", DW'(ic_data_o), DW'(LANE[IW-1:0]));

      // Reset in BUSY: outputs clear at once, no rdy, next request served.
      dc_req_i = 1; dc_we_i = 0; dc_addr_i = 32'h0000_0700;
      tick();
      dc_req_i = 0;
      tick();
      rsn_i = 1'b1;
      #1;
      chk1("arst_rd_req", mm_rd_req_o, 1'b0);
      chk1("arst_dc_rdy", dc_rdy_o, 1'b0);
      chkw("arst_dc_data", dc_data_o, '0);
      chkw("arst_mm_addr", DW'(mm_addr_o), '0);
      model_reset();
      r0 = n_dc_rdy;
      mm_data_rdy_i = 1;
      tick();
      rsn_i = 1'b0;
      repeat (2) tick();
      mm_data_rdy_i = 0;
      chkw("arst_no_rdy", DW'(n_dc_rdy - r0), '0);
      ic_req_i = 1; ic_addr_i = 32'h0000_0500;
      tick();
      ic_req_i = 0;
      chk1("post_rst_gnt", ic_gnt_o, 1'b1);
      mm_data_rdy_i = 1; mm_data_i = LANE;
      tick();
      mm_data_rdy_i = 0;
      chk1("post_rst_rdy", ic_rdy_o, 1'b1);
      repeat (2) tick();

      // Memory never answers.
      dc_req_i = 1; dc_we_i = 0; dc_addr_i = 32'h0000_0600;
      tick();
      dc_req_i = 0;
      n = 0; seen = 0;
`ifdef SEGRE_MM_ARB_TIMEOUT_EN
      while (!seen && n < 30) begin
         tick(); n++;
         seen = dc_rdy_o;
      end
      chkw("to_latency", DW'(n), DW'(TO));
      chk1("to_flag", timeout_o, 1'b1);
      chkw("to_data", dc_data_o, '0);
`else
      repeat (20) begin
         tick();
         if (dc_rdy_o) seen = 1;
      end
      chk1("no_to_rdy", seen, 1'b0);
      chk1("no_to_busy", mm_rd_req_o, 1'b1);
      mm_data_rdy_i = 1; mm_data_i = LANE;
      tick();
      mm_data_rdy_i = 0;
      chk1("no_to_late_rdy", dc_rdy_o, 1'b1);
`endif
      repeat (2) tick();

      // Randomized traffic in windows of differing memory responsiveness.
      for (int w = 0; w < 9; w++) begin
         int pct;
         pct = (w % 3 == 0) ? 5 : ((w % 3 == 1) ? 30 : 80);
         for (int c = 0; c < 200; c++) begin
            drive_random(pct);
            tick();
         end
      end
      dc_req_i = 0; ic_req_i = 0; mm_data_rdy_i = 1;
      repeat (6) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_segre_mm_arbiter

// File: doc/segre_mm_arbiter.md
SEGRE_MM_ARBITER -- requirements
Module: segre_mm_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 256: number of BUSY cycles before a transaction is aborted; used only when SEGRE_MM_ARB_TIMEOUT_EN is defined.
REQ-002 Port clk_i  in  1  single clock; all logic on its rising edge.
REQ-003 Port rsn_i  in  1  asynchronous, active-high reset.
REQ-004 Port dc_req_i  in  1  dcache request, held until dc_gnt_o.
REQ-005 Port dc_we_i  in  1  dcache write-back (1) or refill read (0).
REQ-006 Port dc_addr_i  in  ADDR_SIZE  dcache lane address.
REQ-007 Port dc_data_i  in  DCACHE_LANE_SIZE  write-back lane.
REQ-008 Port dc_gnt_o  out  1  one-cycle accept pulse.
REQ-009 Port dc_rdy_o  out  1  one-cycle completion pulse.
REQ-010 Port dc_data_o  out  DCACHE_LANE_SIZE  refill lane.
REQ-011 Port ic_req_i  in  1  icache refill request, held until ic_gnt_o.
REQ-012 Port ic_addr_i  in  ADDR_SIZE  icache lane address.
REQ-013 Port ic_gnt_o  out  1  one-cycle accept pulse.
REQ-014 Port ic_rdy_o  out  1  one-cycle completion pulse.
REQ-015 Port ic_data_o  out  ICACHE_LANE_SIZE  refill lane.
REQ-016 Ports mm_rd_req_o / mm_wr_req_o  out  1 each  main-memory read / write request.
REQ-017 Port mm_addr_o  out  ADDR_SIZE  main-memory address.
REQ-018 Port mm_data_o  out  DCACHE_LANE_SIZE  main-memory write data.
REQ-019 Port mm_data_rdy_i  in  1  main-memory completion.
REQ-020 Port mm_data_i  in  DCACHE_LANE_SIZE  main-memory read data.
REQ-021 Port timeout_o  out  1  abort flag, pulses together with rdy.

Function
REQ-022 The FSM SHALL have states IDLE, BUSY and RESP.
REQ-023 IDLE: no request -> stay; one request -> latch requester, we, addr, wdata -> BUSY; both requesting -> grant the one not served last (round-robin pointer) -> BUSY.
REQ-024 First BUSY cycle: the granted gnt_o SHALL pulse once; the registered request SHALL be driven (mm_wr_req_o=we, mm_rd_req_o=!we) and held stable through BUSY.
REQ-025 BUSY: mm_data_rdy_i=1 -> capture mm_data_i for a read -> RESP; otherwise stay.
REQ-026 RESP (one cycle): mm requests low; the owner's rdy_o=1; data_o shows the captured lane (icache: low ICACHE_LANE_SIZE bits) -> IDLE; pointer updated to the owner.
REQ-027 Minimum latency SHALL be req in cycle N, gnt N+1, rdy N+2; the next arbitration SHALL happen no earlier than N+3.
REQ-028 A write SHALL pulse dc_rdy_o with dc_data_o unchanged; data_o SHALL hold its last value between transactions.
REQ-029 mm_data_rdy_i outside BUSY SHALL be ignored; requests arriving during BUSY/RESP SHALL wait.
REQ-030 A request deasserted before gnt SHALL be dropped.

Reset
REQ-031 rsn_i=1 SHALL asynchronously force IDLE, all outputs 0, data registers 0 and the pointer to favour dcache; mid-transaction reset SHALL abandon it with no rdy pulse.

Configuration
REQ-032 With SEGRE_MM_ARB_TIMEOUT_EN defined, a BUSY counter (cleared on BUSY entry) reaching TIMEOUT_CYCLES SHALL force RESP with data_o=0 and timeout_o=1 alongside rdy_o.
REQ-033 Without the macro, no counter SHALL exist, timeout_o SHALL be tied 0 and BUSY SHALL wait indefinitely.

Structure
REQ-034 The package SHALL hold the enum mm_arb_state_e and the constant MM_ARB_TIMEOUT_CYCLES; ADDR_SIZE and the lane sizes SHALL come from segre_pkg.
REQ-035 Two-way round-robin selection and pointer SHALL be the sub-module segre_rr_arbiter.

Verification
REQ-036 dc read addr 0x100, mm_data_rdy_i 3 cycles after mm_rd_req_o with lane 0xffee..1100 -> dc_gnt_o once, dc_rdy_o once, dc_data_o=lane.
REQ-037 dc write addr 0x200 data 0xcafe.. -> mm_wr_req_o, mm_addr_o=0x200, mm_data_o=0xcafe..; dc_rdy_o pulses; dc_data_o unchanged.
REQ-038 dc and ic requesting together from reset, both held -> dc served first, ic second, then alternating; no gnt while BUSY.
REQ-039 Reset asserted in BUSY -> all outputs 0 immediately; no rdy pulse; next request served normally.
REQ-040 With the macro and TIMEOUT_CYCLES=8, mm_data_rdy_i never asserted -> after 8 BUSY cycles rdy_o and timeout_o pulse, data_o=0; without the macro -> stays BUSY.
